// File: rtl/chip_if_pkg.sv
// ============================================================================
// chip_if_pkg : frame layout and FSM state encoding shared by the chip FSM
//               control block and the serial decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package chip_if_pkg;

  localparam int CHIP_ADDR_W  = 3;
  localparam int CHIP_DATA_W  = 8;
  localparam int CHIP_FRAME_W = CHIP_ADDR_W + CHIP_DATA_W;

  // Serial bit order on chip_data_in: address MSB first, data LSB last.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } chip_state_t;

endpackage

`default_nettype wire

// File: rtl/chip_line_sampler.sv
// ============================================================================
// chip_line_sampler : registers the chip_* lines, detects chip_clk rising
//                     edges and times out a stalled frame.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module chip_line_sampler #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic chip_rst,
  input  logic chip_clk,
  input  logic chip_data_in,
  input  logic timer_en,
  output logic line_rst,
  output logic line_data,
  output logic rise,
  output logic timeout
);

  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

  logic          r1_rst;
  logic          r1_clk;
  logic          r1_data;
  logic          r2_clk;
  logic [TW-1:0] r_idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_rst  <= 1'b0;
      r1_clk  <= 1'b0;
      r1_data <= 1'b0;
      r2_clk  <= 1'b0;
    end else begin
      r1_rst  <= chip_rst;
      r1_clk  <= chip_clk;
      r1_data <= chip_data_in;
      r2_clk  <= r1_clk;
    end
  end

  assign rise      = r1_clk & ~r2_clk;
  assign line_rst  = r1_rst;
  assign line_data = r1_data;

  // Counts only while a frame is in progress; parks at the limit until the
  // FSM leaves SHIFT, which clears it.
  always_ff @(posedge clk) begin
    if (!rst_n || !timer_en || rise) begin
      r_idle_cnt <= '0;
    end else if (!timeout) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign timeout = (r_idle_cnt == TMO_LIMIT);

endmodule

`default_nettype wire

// File: rtl/chip_serial_decoder.sv
// ============================================================================
// chip_serial_decoder : decodes serial DAC-programming frames into a shadow
//                       register file, with frame/error reporting.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module chip_serial_decoder
  import chip_if_pkg::*;
#(
  parameter int ADDR_W      = CHIP_ADDR_W,
  parameter int DATA_W      = CHIP_DATA_W,
  parameter int NUM_DAC     = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chip_rst,
  input  logic              chip_clk,
  input  logic              chip_data_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_changed,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int            FRAME_W  = ADDR_W + DATA_W;
  localparam int            BW       = $clog2(FRAME_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);

  logic w_line_rst;
  logic w_line_data;
  logic w_rise;
  logic w_timeout;

  chip_state_t r_state;
  chip_state_t w_state_next;

  logic               w_start;
  logic               w_take;
  logic               w_commit;
  logic               w_err;
  logic [BW-1:0]      r_bit_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [DATA_W-1:0]  r_shadow [NUM_DAC];

  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  chip_line_sampler #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_sampler (
    .clk          (clk),
    .rst_n        (rst_n),
    .chip_rst     (chip_rst),
    .chip_clk     (chip_clk),
    .chip_data_in (chip_data_in),
    .timer_en     (r_state == SHIFT),
    .line_rst     (w_line_rst),
    .line_data    (w_line_data),
    .rise         (w_rise),
    .timeout      (w_timeout)
  );

  function automatic logic [FRAME_W-1:0] shift_in(input logic [FRAME_W-1:0] base,
                                                  input logic               b);
    return MSB_FIRST ? {base[FRAME_W-2:0], b} : {b, base[FRAME_W-1:1]};
  endfunction

  assign w_addr = r_shift[FRAME_W-1 -: ADDR_W];
  assign w_data = r_shift[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take       = 1'b0;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    if (w_line_rst) begin
      // Chip reset wins over everything, including a frame about to commit.
      w_state_next = HOLD;
      w_err        = w_rise;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_start      = 1'b1;
            w_state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (w_rise) begin
            w_take = 1'b1;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_next = DONE;
            end
          end else if (w_timeout) begin
            w_err        = 1'b1;
            w_state_next = IDLE;
          end
        end
        DONE: begin
          w_commit = 1'b1;
          if (w_rise) begin
            w_start      = 1'b1;
            w_state_next = SHIFT;
          end else begin
            w_state_next = IDLE;
          end
        end
        HOLD: begin
          w_err        = w_rise;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      rd_data       <= '0;
      frame_valid   <= 1'b0;
      frame_addr    <= '0;
      frame_data    <= '0;
      frame_changed <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
      for (int i = 0; i < NUM_DAC; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      rd_data     <= r_shadow[rd_addr];
      frame_valid <= w_commit;
      frame_err   <= w_err;

      if (w_start) begin
        r_shift   <= shift_in('0, w_line_data);
        r_bit_cnt <= BW'(1);
      end else if (w_take) begin
        r_shift   <= shift_in(r_shift, w_line_data);
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_state_next != SHIFT) begin
        r_bit_cnt <= '0;
      end

      if (w_line_rst) begin
        for (int i = 0; i < NUM_DAC; i++) begin
          r_shadow[i] <= '0;
        end
      end else if (w_commit) begin
        r_shadow[w_addr] <= w_data;
        frame_addr       <= w_addr;
        frame_data       <= w_data;
        frame_changed    <= (r_shadow[w_addr] != w_data);
        if (frame_cnt != {CNT_W{1'b1}}) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      if (w_err && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
